// File: rtl/leglite_pkg.sv
// -----------------------------------------------------------------------------
// leglite_pkg
// Shared types and constants for the LEGLite instruction-fetch slice.
//   ifetch_state_t : fetch controller states (IDLE, FETCH, FULL, HALT)
//   INSTR_W/ADDR_W : instruction word and byte-address widths
//   PC_RESET       : address reported in instr_pc after reset
// -----------------------------------------------------------------------------
package leglite_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  localparam logic [ADDR_W-1:0] PC_RESET = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2,
    HALT  = 2'd3
  } ifetch_state_t;

endpackage : leglite_pkg

// File: rtl/ifetch_watchdog.sv
// -----------------------------------------------------------------------------
// ifetch_watchdog
// Counts consecutive cycles spent waiting on instruction memory and flags the
// cycle in which the wait reaches TIMEOUT_CYCLES (legal range 2..255).
// Ports:
//   clock    : clock, all updates on posedge
//   reset    : synchronous active-high reset
//   clear    : zero the counter (driven while the fetcher is outside FETCH)
//   count_en : one more waiting cycle has elapsed at this edge
//   expired  : combinational; high during the TIMEOUT_CYCLES-th waiting cycle
// -----------------------------------------------------------------------------
module ifetch_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  // The counter holds the number of waiting cycles already completed, so the
  // TIMEOUT_CYCLES-th cycle is the one where it reads TIMEOUT_CYCLES-1.
  localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= 8'd0;
    end else if (count_en) begin
      count <= count + 8'd1;
    end
  end

  assign expired = count_en && (count == LAST);

endmodule : ifetch_watchdog

// File: rtl/leglite_ifetch.sv
// -----------------------------------------------------------------------------
// leglite_ifetch
// Instruction-fetch stage of the LEGLite core. Requests the word at the current
// PC from a variable-latency memory, buffers one returned instruction until
// decode accepts it, and stalls the PC logic until that consume happens.
// Optional memory-timeout watchdog enabled by the IFETCH_TIMEOUT_EN macro.
// Ports:
//   clock, reset           : clock and synchronous active-high reset
//   pc                     : current PC (held by PC logic while pc_stall=1)
//   flush                  : one-cycle redirect; drops buffered/in-flight word
//   mem_req, mem_addr      : memory request and even byte address
//   mem_ack, mem_rdata     : one-cycle acknowledge with data in the same cycle
//   instr, instr_pc        : buffered instruction and its fetch address
//   instr_valid            : buffer holds a valid instruction
//   decode_ready           : decode takes instr at this edge
//   pc_stall               : PC logic must hold pc
//   instr_count            : consumed-instruction count (wraps at 16 bits)
//   fetch_fault            : sticky memory-timeout flag (0 without the macro)
// -----------------------------------------------------------------------------
module leglite_ifetch
  import leglite_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               flush,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               decode_ready,
  output logic               pc_stall,
  output logic [15:0]        instr_count,
  output logic               fetch_fault
);

  ifetch_state_t state;
  logic          timeout;

  // Instructions are halfword aligned; pc[0] is never part of the address.
  assign mem_addr = {pc[ADDR_W-1:1], 1'b0};
  assign mem_req  = (state == FETCH);

  // The PC may move only on the edge where decode takes the buffered word.
  assign pc_stall = !((state == FULL) && decode_ready && !flush);

  logic unused_pc0;
  assign unused_pc0 = pc[0];

  // NOTE: every register here is written with <= so all of them sample the
  // pre-edge values together; a blocking = would let later statements see
  // already-updated state and silently change the behaviour.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      instr       <= '0;
      instr_pc    <= PC_RESET;
      instr_valid <= 1'b0;
      instr_count <= 16'd0;
    end else begin
      case (state)
        IDLE: state <= FETCH;

        FETCH: begin
          // Timeout outranks flush, which outranks a returning ack.
          if (timeout) begin
            state <= HALT;
          end else if (flush) begin
            state <= IDLE;
          end else if (mem_ack) begin
            instr       <= mem_rdata;
            instr_pc    <= mem_addr;
            instr_valid <= 1'b1;
            state       <= FULL;
          end
        end

        FULL: begin
          if (flush) begin
            instr_valid <= 1'b0;
            state       <= IDLE;
          end else if (decode_ready) begin
            instr_valid <= 1'b0;
            instr_count <= instr_count + 16'd1;
            state       <= FETCH;
          end
        end

        HALT: state <= HALT;

        default: state <= IDLE;
      endcase
    end
  end

`ifdef IFETCH_TIMEOUT_EN
  logic wd_expired;

  ifetch_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock    (clock),
    .reset    (reset),
    .clear    (state != FETCH),
    .count_en (state == FETCH),
    .expired  (wd_expired)
  );

  assign timeout = wd_expired;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_fault <= 1'b0;
    end else if (timeout) begin
      fetch_fault <= 1'b1;
    end
  end
`else
  // Without the watchdog FETCH waits forever and HALT is unreachable.
  assign timeout     = 1'b0;
  assign fetch_fault = 1'b0;

  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

endmodule : leglite_ifetch
